// File: rtl/mac_array_pkg.sv
// Shared constants for the weight-stationary MAC array: inst encoding and default widths.
// Optional build macro MAC_ARRAY_SAT_EN is consumed by mac_tile (saturating accumulation).
package mac_array_pkg;

    localparam logic [1:0] INST_NOP     = 2'b00;
    localparam logic [1:0] INST_LOAD    = 2'b01;
    localparam logic [1:0] INST_EXEC    = 2'b10;
    localparam logic [1:0] INST_ILLEGAL = 2'b11;

    localparam int BW_DEF        = 4;
    localparam int PSUM_BW_DEF   = 16;
    localparam int COL_DEF       = 8;
    localparam int ROW_DEF       = 8;
    localparam int INDEX_SEL_DEF = 2;

    // The illegal code carries no meaning downstream; fold it into a bubble at entry.
    function automatic logic [1:0] inst_clean(input logic [1:0] inst);
        return (inst == INST_ILLEGAL) ? INST_NOP : inst;
    endfunction

endpackage

// File: rtl/mac_tile.sv
// One processing element: stationary signed weight, a/inst/skip pipeline, MAC and psum register.
// Build macro MAC_ARRAY_SAT_EN selects saturating instead of wrapping accumulation.
module mac_tile
    import mac_array_pkg::*;
#(
    parameter int bw      = BW_DEF,
    parameter int psum_bw = PSUM_BW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw-1:0]      a_w,
    input  logic [1:0]         inst_w,
    input  logic               skip_w,
    input  logic [psum_bw-1:0] psum_n,
    output logic [bw-1:0]      a_e,
    output logic [1:0]         inst_e,
    output logic               skip_e,
    output logic [psum_bw-1:0] psum_s,
    output logic               valid_s
);

    logic [bw-1:0]             a_q;
    logic [1:0]                inst_q;
    logic                      skip_q;
    logic signed [bw-1:0]      w_q;
    logic                      load_ready;
    logic [psum_bw-1:0]        psum_q;
    logic                      valid_q;
    logic [1:0]                inst_in;
    logic signed [psum_bw-1:0] a_ext;
    logic signed [psum_bw-1:0] w_ext;
    logic signed [psum_bw-1:0] prod;
    logic signed [psum_bw-1:0] addend;
    logic [psum_bw-1:0]        psum_next;

    assign inst_in = inst_clean(inst_w);

    // A loading tile swallows the load it captures so the next vector reaches the next column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q        <= '0;
            inst_q     <= INST_NOP;
            skip_q     <= 1'b0;
            w_q        <= '0;
            load_ready <= 1'b1;
        end else begin
            a_q    <= a_w;
            skip_q <= skip_w;
            inst_q <= inst_in;
            if (inst_in == INST_LOAD && load_ready) begin
                w_q        <= a_w;
                load_ready <= 1'b0;
                inst_q     <= {inst_in[1], 1'b0};
            end
        end
    end

    // Activation is unsigned, weight is two's complement; both widened before multiplying.
    assign a_ext  = $signed({{(psum_bw-bw){1'b0}}, a_q});
    assign w_ext  = {{(psum_bw-bw){w_q[bw-1]}}, w_q};
    assign prod   = a_ext * w_ext;
    assign addend = skip_q ? '0 : prod;

`ifdef MAC_ARRAY_SAT_EN
    logic [psum_bw:0] sum_wide;

    assign sum_wide = {psum_n[psum_bw-1], psum_n} + {addend[psum_bw-1], addend};

    always_comb begin
        psum_next = sum_wide[psum_bw-1:0];
        if (sum_wide[psum_bw] != sum_wide[psum_bw-1]) begin
            psum_next = sum_wide[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                          : {1'b0, {(psum_bw-1){1'b1}}};
        end
    end
`else
    assign psum_next = psum_n + addend;
`endif

    // Bubbles leave psum untouched so the bottom row holds its last result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psum_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (inst_q == INST_EXEC);
            if (inst_q == INST_EXEC) begin
                psum_q <= psum_next;
            end
        end
    end

    assign a_e     = a_q;
    assign inst_e  = inst_q;
    assign skip_e  = skip_q;
    assign psum_s  = psum_q;
    assign valid_s = valid_q;

endmodule

// File: rtl/mac_systolic_array.sv
// Weight-stationary row x col systolic MAC grid; data flows east, partial sums flow south.
// Build macro MAC_ARRAY_SAT_EN enables saturating accumulation in every tile.
module mac_systolic_array
    import mac_array_pkg::*;
#(
    parameter int bw              = BW_DEF,
    parameter int psum_bw         = PSUM_BW_DEF,
    parameter int col             = COL_DEF,
    parameter int row             = ROW_DEF,
    parameter int index_selection = INDEX_SEL_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [row*bw-1:0]              in_w,
    input  logic [psum_bw*col-1:0]         in_n,
    input  logic [1:0]                     inst_w,
    input  logic [row/index_selection-1:0] index_w,
    output logic [psum_bw*col-1:0]         out_s,
    output logic [col-1:0]                 valid
);

    // There is no handshake: every non-bubble inst_w cycle is accepted, and each
    // out_s column is qualified only by its valid bit; nothing ever stalls.

    logic [bw-1:0]      a_bus     [row][col+1];
    logic [1:0]         inst_bus  [row][col+1];
    logic               skip_bus  [row][col+1];
    logic [psum_bw-1:0] psum_bus  [row+1][col];
    logic               valid_bus [row][col];

    for (genvar r = 0; r < row; r++) begin : g_row
        localparam int grp = r / index_selection;

        assign a_bus[r][0] = in_w[bw*r +: bw];

        // The feeder skews in_w by row; inst and the group skip bit get the same delay here.
        if (r == 0) begin : g_direct
            assign inst_bus[r][0] = inst_w;
            assign skip_bus[r][0] = index_w[grp];
        end else begin : g_delay
            logic [3*r-1:0] dly;

            if (r == 1) begin : g_one
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) dly <= '0;
                    else        dly <= {inst_w, index_w[grp]};
                end
            end else begin : g_many
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) dly <= '0;
                    else        dly <= {dly[3*r-4:0], inst_w, index_w[grp]};
                end
            end

            assign inst_bus[r][0] = dly[3*r-1 -: 2];
            assign skip_bus[r][0] = dly[3*r-3];
        end

        logic unused_east;
        assign unused_east = ^{a_bus[r][col], inst_bus[r][col], skip_bus[r][col]};

        for (genvar c = 0; c < col; c++) begin : g_col
            mac_tile #(
                .bw      (bw),
                .psum_bw (psum_bw)
            ) u_tile (
                .clk     (clk),
                .reset   (reset),
                .a_w     (a_bus[r][c]),
                .inst_w  (inst_bus[r][c]),
                .skip_w  (skip_bus[r][c]),
                .psum_n  (psum_bus[r][c]),
                .a_e     (a_bus[r][c+1]),
                .inst_e  (inst_bus[r][c+1]),
                .skip_e  (skip_bus[r][c+1]),
                .psum_s  (psum_bus[r+1][c]),
                .valid_s (valid_bus[r][c])
            );

            if (r < row - 1) begin : g_inner
                logic unused_valid;
                assign unused_valid = valid_bus[r][c];
            end
        end
    end

    for (genvar c = 0; c < col; c++) begin : g_edge
        assign psum_bus[0][c]            = in_n[psum_bw*c +: psum_bw];
        assign out_s[psum_bw*c +: psum_bw] = psum_bus[row][c];
        assign valid[c]                  = valid_bus[row-1][c];
    end

endmodule

// File: tb/tb_mac_systolic_array.sv
// Self-checking bench for mac_systolic_array against a matrix-product reference model.
// Honours MAC_ARRAY_SAT_EN the same way as the design build.
module tb_mac_systolic_array;

    localparam int BW   = 4;
    localparam int PW   = 16;
    localparam int COL  = 8;
    localparam int ROW  = 8;
    localparam int ISEL = 2;
    localparam int NG   = ROW / ISEL;
    localparam int MAXV = 64;
    localparam int MAXT = MAXV + ROW + COL + 4;
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_EXEC = 2'b10;
    localparam logic [1:0] OP_BAD  = 2'b11;

    // ---------------- clock / reset / DUT ----------------
    logic                clk = 1'b0;
    logic                reset;
    logic [ROW*BW-1:0]   in_w;
    logic [PW*COL-1:0]   in_n;
    logic [1:0]          inst_w;
    logic [NG-1:0]       index_w;
    logic [PW*COL-1:0]   out_s;
    logic [COL-1:0]      valid;

    always #5 clk = ~clk;

    mac_systolic_array dut (
        .clk     (clk),
        .reset   (reset),
        .in_w    (in_w),
        .in_n    (in_n),
        .inst_w  (inst_w),
        .index_w (index_w),
        .out_s   (out_s),
        .valid   (valid)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- program (one entry per vector entering row 0) ----------------
    int             n_vec;
    int             n_cyc;
    logic [1:0]     p_inst [MAXV];
    logic [NG-1:0]  p_idx  [MAXV];
    logic [BW-1:0]  p_vec  [MAXV][ROW];
    logic [PW-1:0]  p_seed [COL];

    // ---------------- reference model and scoreboard ----------------
    logic signed [BW-1:0] m_w    [ROW][COL];
    int                   m_loads;
    logic [PW-1:0]        m_last [COL];
    logic [PW-1:0]        m_res  [MAXV][COL];
    logic [PW-1:0]        exp_q[$];
    logic                 exp_v    [MAXT][COL];
    logic [PW-1:0]        exp_hold [MAXT][COL];
    logic                 cap_v    [MAXT][COL];
    logic [PW-1:0]        cap_out  [MAXT][COL];
    logic [PW-1:0]        ev;

    task automatic model_reset();
        m_loads = 0;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) m_w[r][c] = '0;
        for (int c = 0; c < COL; c++) m_last[c] = '0;
        exp_q.delete();
    endtask

    // Matrix-product model: k-th load fills column k; exec result appears at edge k+ROW+c.
    task automatic build_expected();
        int acc;
        int k;
        for (int v = 0; v < n_vec; v++) begin
            if (p_inst[v] == OP_LOAD) begin
                if (m_loads < COL) begin
                    for (int r = 0; r < ROW; r++) m_w[r][m_loads] = p_vec[v][r];
                    m_loads++;
                end
            end else if (p_inst[v] == OP_EXEC) begin
                for (int c = 0; c < COL; c++) begin
                    acc = int'($signed(p_seed[c]));
                    for (int r = 0; r < ROW; r++) begin
                        if (!p_idx[v][r/ISEL]) begin
                            acc = acc + int'(p_vec[v][r]) * int'(m_w[r][c]);
`ifdef MAC_ARRAY_SAT_EN
                            if (acc > 32767) acc = 32767;
                            if (acc < -32768) acc = -32768;
`endif
                        end
                    end
                    m_res[v][c] = acc[PW-1:0];
                end
            end
        end
        n_cyc = n_vec + ROW + COL + 2;
        for (int t = 0; t < n_cyc; t++) begin
            for (int c = 0; c < COL; c++) begin
                k = t - ROW - c;
                if (k >= 0 && k < n_vec && p_inst[k] == OP_EXEC) begin
                    exp_v[t][c] = 1'b1;
                    m_last[c] = m_res[k][c];
                    exp_q.push_back(m_res[k][c]);
                end else begin
                    exp_v[t][c] = 1'b0;
                end
                exp_hold[t][c] = m_last[c];
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_program();
        n_vec = 0;
    endtask

    task automatic add_uniform(input logic [1:0] inst, input logic [NG-1:0] idx, input logic [BW-1:0] val);
        p_inst[n_vec] = inst;
        p_idx[n_vec]  = idx;
        for (int r = 0; r < ROW; r++) p_vec[n_vec][r] = val;
        n_vec++;
    endtask

    task automatic add_random(input logic [1:0] inst, input logic [NG-1:0] idx);
        p_inst[n_vec] = inst;
        p_idx[n_vec]  = idx;
        for (int r = 0; r < ROW; r++) p_vec[n_vec][r] = BW'($urandom_range(0, (1 << BW) - 1));
        n_vec++;
    endtask

    task automatic set_seeds(input logic [PW-1:0] val, input bit rnd);
        for (int c = 0; c < COL; c++) p_seed[c] = rnd ? PW'($urandom_range(0, 65535)) : val;
    endtask

    task automatic drive_idle();
        in_w    = '0;
        in_n    = '0;
        inst_w  = OP_NOP;
        index_w = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Feeds in_w with the row skew; captures outputs #1 after each edge. abort_at<0 runs to the end.
    task automatic run_program(input int abort_at);
        int k;
        for (int t = 0; t < n_cyc; t++) begin
            for (int r = 0; r < ROW; r++) begin
                k = t - r;
                in_w[BW*r +: BW] = (k >= 0 && k < n_vec) ? p_vec[k][r] : '0;
            end
            inst_w  = (t < n_vec) ? p_inst[t] : OP_NOP;
            index_w = (t < n_vec) ? p_idx[t] : '0;
            for (int c = 0; c < COL; c++) in_n[PW*c +: PW] = p_seed[c];
            if (t == abort_at) begin
                #2;
                reset = 1'b0;
                #1;
                return;
            end
            @(posedge clk);
            #1;
            for (int c = 0; c < COL; c++) begin
                cap_v[t][c]   = valid[c];
                cap_out[t][c] = out_s[PW*c +: PW];
            end
        end
        drive_idle();
    endtask

    task automatic add_loads_uniform(input logic [BW-1:0] val);
        for (int j = 0; j < COL; j++) add_uniform(OP_LOAD, NG'($urandom_range(0, (1 << NG) - 1)), val);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        do_reset();
        checks++;
        if (out_s !== '0) begin errors++; $display("FAIL reset_out got=%h exp=0", out_s); end
        checks++;
        if (valid !== '0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    endtask

    task automatic test_ones();
        model_reset();
        do_reset();
        clear_program();
        add_loads_uniform(4'h1);
        add_uniform(OP_EXEC, '0, 4'h3);
        set_seeds('0, 1'b0);
        build_expected();
        run_program(-1);
        for (int t = 0; t < n_cyc; t++)
            for (int c = 0; c < COL; c++) begin
                checks++;
                if (cap_v[t][c] !== exp_v[t][c]) begin errors++; $display("FAIL ones_valid t=%0d c=%0d got=%b exp=%b", t, c, cap_v[t][c], exp_v[t][c]); end
                ev = exp_v[t][c] ? exp_q.pop_front() : exp_hold[t][c];
                checks++;
                if (cap_out[t][c] !== ev) begin errors++; $display("FAIL ones_out t=%0d c=%0d got=%h exp=%h", t, c, cap_out[t][c], ev); end
            end
        for (int c = 0; c < COL; c++) begin
            checks++;
            if (cap_v[COL+ROW+c][c] !== 1'b1 || cap_out[COL+ROW+c][c] !== 16'h0018) begin
                errors++;
                $display("FAIL ones_const c=%0d got=%h/%b exp=0018/1", c, cap_out[COL+ROW+c][c], cap_v[COL+ROW+c][c]);
            end
        end
    endtask

    task automatic test_negative();
        model_reset();
        do_reset();
        clear_program();
        add_loads_uniform(4'hF);
        add_uniform(OP_EXEC, '0, 4'hF);
        set_seeds(16'h0100, 1'b0);
        build_expected();
        run_program(-1);
        for (int t = 0; t < n_cyc; t++)
            for (int c = 0; c < COL; c++) begin
                checks++;
                if (cap_v[t][c] !== exp_v[t][c]) begin errors++; $display("FAIL neg_valid t=%0d c=%0d got=%b exp=%b", t, c, cap_v[t][c], exp_v[t][c]); end
                ev = exp_v[t][c] ? exp_q.pop_front() : exp_hold[t][c];
                checks++;
                if (cap_out[t][c] !== ev) begin errors++; $display("FAIL neg_out t=%0d c=%0d got=%h exp=%h", t, c, cap_out[t][c], ev); end
            end
        for (int c = 0; c < COL; c++) begin
            checks++;
            if (out_s[PW*c +: PW] !== 16'h0088) begin errors++; $display("FAIL neg_const c=%0d got=%h exp=0088", c, out_s[PW*c +: PW]); end
        end
    endtask

    task automatic test_back_to_back();
        model_reset();
        do_reset();
        clear_program();
        for (int j = 0; j < COL; j++) add_random(OP_LOAD, '0);
        for (int v = 0; v < 36; v++) add_random(OP_EXEC, '0);
        set_seeds('0, 1'b1);
        build_expected();
        run_program(-1);
        for (int t = 0; t < n_cyc; t++)
            for (int c = 0; c < COL; c++) begin
                checks++;
                if (cap_v[t][c] !== exp_v[t][c]) begin errors++; $display("FAIL stream_valid t=%0d c=%0d got=%b exp=%b", t, c, cap_v[t][c], exp_v[t][c]); end
                ev = exp_v[t][c] ? exp_q.pop_front() : exp_hold[t][c];
                checks++;
                if (cap_out[t][c] !== ev) begin errors++; $display("FAIL stream_out t=%0d c=%0d got=%h exp=%h", t, c, cap_out[t][c], ev); end
            end
    endtask

    task automatic test_sparse();
        model_reset();
        do_reset();
        clear_program();
        add_loads_uniform(4'h1);
        add_uniform(OP_LOAD, '0, 4'h5);
        add_uniform(OP_EXEC, 4'b0001, 4'h1);
        add_random(OP_BAD, NG'($urandom_range(0, (1 << NG) - 1)));
        add_random(OP_EXEC, NG'($urandom_range(0, (1 << NG) - 1)));
        add_random(OP_NOP, '0);
        add_random(OP_EXEC, NG'($urandom_range(0, (1 << NG) - 1)));
        add_uniform(OP_EXEC, 4'b0001, 4'h1);
        set_seeds('0, 1'b0);
        build_expected();
        run_program(-1);
        for (int t = 0; t < n_cyc; t++)
            for (int c = 0; c < COL; c++) begin
                checks++;
                if (cap_v[t][c] !== exp_v[t][c]) begin errors++; $display("FAIL sparse_valid t=%0d c=%0d got=%b exp=%b", t, c, cap_v[t][c], exp_v[t][c]); end
                ev = exp_v[t][c] ? exp_q.pop_front() : exp_hold[t][c];
                checks++;
                if (cap_out[t][c] !== ev) begin errors++; $display("FAIL sparse_out t=%0d c=%0d got=%h exp=%h", t, c, cap_out[t][c], ev); end
            end
        for (int c = 0; c < COL; c++) begin
            checks++;
            if (cap_out[9+ROW+c][c] !== 16'd6) begin errors++; $display("FAIL sparse_const c=%0d got=%h exp=0006", c, cap_out[9+ROW+c][c]); end
            checks++;
            if (cap_v[10+ROW+c][c] !== 1'b0) begin errors++; $display("FAIL sparse_illegal c=%0d got=%b exp=0", c, cap_v[10+ROW+c][c]); end
        end
    endtask

    task automatic test_saturation();
        logic [PW-1:0] want;
`ifdef MAC_ARRAY_SAT_EN
        want = 16'h7FFF;
`else
        want = 16'h8338;
`endif
        model_reset();
        do_reset();
        clear_program();
        add_loads_uniform(4'h7);
        add_uniform(OP_EXEC, '0, 4'hF);
        set_seeds(16'h7FF0, 1'b0);
        build_expected();
        run_program(-1);
        for (int t = 0; t < n_cyc; t++)
            for (int c = 0; c < COL; c++) begin
                checks++;
                if (cap_v[t][c] !== exp_v[t][c]) begin errors++; $display("FAIL sat_valid t=%0d c=%0d got=%b exp=%b", t, c, cap_v[t][c], exp_v[t][c]); end
                ev = exp_v[t][c] ? exp_q.pop_front() : exp_hold[t][c];
                checks++;
                if (cap_out[t][c] !== ev) begin errors++; $display("FAIL sat_out t=%0d c=%0d got=%h exp=%h", t, c, cap_out[t][c], ev); end
            end
        for (int c = 0; c < COL; c++) begin
            checks++;
            if (out_s[PW*c +: PW] !== want) begin errors++; $display("FAIL sat_const c=%0d got=%h exp=%h", c, out_s[PW*c +: PW], want); end
        end
    endtask

    task automatic test_reset_mid();
        int abort_at;
        model_reset();
        do_reset();
        clear_program();
        for (int j = 0; j < COL; j++) add_random(OP_LOAD, '0);
        for (int v = 0; v < 20; v++) add_random(OP_EXEC, NG'($urandom_range(0, (1 << NG) - 1)));
        set_seeds('0, 1'b1);
        build_expected();
        abort_at = $urandom_range(COL + ROW + 2, n_cyc - 6);
        run_program(abort_at);
        checks++;
        if (out_s !== '0) begin errors++; $display("FAIL midreset_out t=%0d got=%h exp=0", abort_at, out_s); end
        checks++;
        if (valid !== '0) begin errors++; $display("FAIL midreset_valid t=%0d got=%b exp=0", abort_at, valid); end
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        build_expected();
        run_program(-1);
        for (int t = 0; t < n_cyc; t++)
            for (int c = 0; c < COL; c++) begin
                checks++;
                if (cap_v[t][c] !== exp_v[t][c]) begin errors++; $display("FAIL rerun_valid t=%0d c=%0d got=%b exp=%b", t, c, cap_v[t][c], exp_v[t][c]); end
                ev = exp_v[t][c] ? exp_q.pop_front() : exp_hold[t][c];
                checks++;
                if (cap_out[t][c] !== ev) begin errors++; $display("FAIL rerun_out t=%0d c=%0d got=%h exp=%h", t, c, cap_out[t][c], ev); end
            end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b0;
        drive_idle();
        test_reset();
        test_ones();
        test_negative();
        test_back_to_back();
        test_sparse();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
